// File: rtl/snax_local_mem_arbiter.sv
// snax_local_mem_arbiter: shares the banked local scratchpad between narrow cores and one wide DMA port.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   core_q_* / core_p_*           per-core narrow request (valid/ready/addr/write/data/strb) and read response
//   dma_q_* / dma_p_*             wide DMA request spanning all banks and its read response
//   dma_access_o                  bank array serves the DMA this cycle
//   bank_*_o / bank_rdata_i       bank array interface, read data one cycle after bank_req_o
module snax_local_mem_arbiter #(
    parameter int unsigned NumCores        = 4,
    parameter int unsigned NumBanks        = 16,
    parameter int unsigned NarrowDataWidth = 32,
    parameter int unsigned BankAddrWidth   = 10,
    parameter int unsigned MaxDmaStall     = 8,
    localparam int unsigned BankSelW  = $clog2(NumBanks),
    localparam int unsigned CoreAddrW = 2 + BankSelW + BankAddrWidth,
    localparam int unsigned WideW     = NumBanks * NarrowDataWidth,
    localparam int unsigned StrbW     = NarrowDataWidth / 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumCores-1:0]                 core_q_valid_i,
    output logic [NumCores-1:0]                 core_q_ready_o,
    input  logic [NumCores*CoreAddrW-1:0]       core_q_addr_i,
    input  logic [NumCores-1:0]                 core_q_write_i,
    input  logic [NumCores*NarrowDataWidth-1:0] core_q_data_i,
    input  logic [NumCores*StrbW-1:0]           core_q_strb_i,
    output logic [NumCores-1:0]                 core_p_valid_o,
    output logic [NumCores*NarrowDataWidth-1:0] core_p_data_o,
    input  logic                                dma_q_valid_i,
    output logic                                dma_q_ready_o,
    input  logic [CoreAddrW-1:0]                dma_q_addr_i,
    input  logic                                dma_q_write_i,
    input  logic [WideW-1:0]                    dma_q_data_i,
    input  logic [WideW/8-1:0]                  dma_q_strb_i,
    output logic                                dma_p_valid_o,
    output logic [WideW-1:0]                    dma_p_data_o,
    output logic                                dma_access_o,
    output logic [NumBanks-1:0]                 bank_req_o,
    output logic [NumBanks-1:0]                 bank_we_o,
    output logic [NumBanks*BankAddrWidth-1:0]   bank_addr_o,
    output logic [NumBanks*NarrowDataWidth-1:0] bank_wdata_o,
    output logic [NumBanks*StrbW-1:0]           bank_be_o,
    input  logic [NumBanks*NarrowDataWidth-1:0] bank_rdata_i
);

    localparam int unsigned CoreIdW = NumCores > 1 ? $clog2(NumCores) : 1;
    // Kept at least one bit wide so MaxDmaStall=0 still elaborates; wait_q then stays 0 and DMA always wins.
    localparam int unsigned WaitW   = MaxDmaStall > 0 ? $clog2(MaxDmaStall + 1) : 1;

    logic [BankSelW-1:0]      core_bank [NumCores];
    logic [BankAddrWidth-1:0] core_word [NumCores];
    logic [BankAddrWidth-1:0] dma_word;
    logic [NumBanks-1:0]      win_v;
    logic [CoreIdW-1:0]       win_id [NumBanks];
    logic [CoreIdW-1:0]       idx;
    logic [CoreIdW-1:0]       rr_q [NumBanks];
    logic [NumBanks-1:0]      rd_v_q;
    logic [CoreIdW-1:0]       rd_id_q [NumBanks];
    logic                     dma_rd_q;
    logic [WaitW-1:0]         wait_q;
    logic                     dma_sel;
    logic                     unused_addr_bits;

    // Byte offset and out-of-window DMA bits carry no routing information.
    assign unused_addr_bits = ^{core_q_addr_i, dma_q_addr_i};

    assign dma_word      = dma_q_addr_i[2+BankSelW +: BankAddrWidth];
    assign dma_sel       = dma_q_valid_i && (core_q_valid_i == '0 || wait_q == WaitW'(MaxDmaStall));
    assign dma_q_ready_o = dma_sel;
    assign dma_access_o  = dma_sel;
    assign dma_p_valid_o = dma_rd_q;
    assign dma_p_data_o  = dma_rd_q ? bank_rdata_i : '0;

    always_comb begin
        for (int c = 0; c < NumCores; c++) begin
            core_bank[c] = core_q_addr_i[c*CoreAddrW+2 +: BankSelW];
            core_word[c] = core_q_addr_i[c*CoreAddrW+2+BankSelW +: BankAddrWidth];
        end
    end

    // Walk the cyclic order downwards so the last hit is the first requester at or after rr_q[b].
    always_comb begin
        idx = '0;
        for (int b = 0; b < NumBanks; b++) begin
            win_v[b]  = 1'b0;
            win_id[b] = '0;
            for (int i = NumCores - 1; i >= 0; i--) begin
                idx = CoreIdW'((int'(rr_q[b]) + i) % NumCores);
                if (core_q_valid_i[idx] && core_bank[idx] == BankSelW'(b)) begin
                    win_v[b]  = 1'b1;
                    win_id[b] = idx;
                end
            end
        end
    end

    always_comb begin
        bank_req_o     = '0;
        bank_we_o      = '0;
        bank_addr_o    = '0;
        bank_wdata_o   = '0;
        bank_be_o      = '0;
        core_q_ready_o = '0;
        for (int b = 0; b < NumBanks; b++) begin
            if (dma_sel) begin
                bank_req_o[b]                                  = 1'b1;
                bank_we_o[b]                                   = dma_q_write_i;
                bank_addr_o[b*BankAddrWidth +: BankAddrWidth]  = dma_word;
                bank_wdata_o[b*NarrowDataWidth +: NarrowDataWidth] = dma_q_data_i[b*NarrowDataWidth +: NarrowDataWidth];
                bank_be_o[b*StrbW +: StrbW]                    = dma_q_strb_i[b*StrbW +: StrbW];
            end else if (win_v[b]) begin
                bank_req_o[b]                                  = 1'b1;
                bank_we_o[b]                                   = core_q_write_i[win_id[b]];
                bank_addr_o[b*BankAddrWidth +: BankAddrWidth]  = core_word[win_id[b]];
                bank_wdata_o[b*NarrowDataWidth +: NarrowDataWidth] = core_q_data_i[win_id[b]*NarrowDataWidth +: NarrowDataWidth];
                bank_be_o[b*StrbW +: StrbW]                    = core_q_strb_i[win_id[b]*StrbW +: StrbW];
                core_q_ready_o[win_id[b]]                      = 1'b1;
            end
        end
    end

    // A core targets one bank, so at most one bank can hold a response for it.
    always_comb begin
        core_p_valid_o = '0;
        core_p_data_o  = '0;
        for (int b = 0; b < NumBanks; b++) begin
            if (rd_v_q[b]) begin
                core_p_valid_o[rd_id_q[b]]                                  = 1'b1;
                core_p_data_o[rd_id_q[b]*NarrowDataWidth +: NarrowDataWidth] = bank_rdata_i[b*NarrowDataWidth +: NarrowDataWidth];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NumBanks; b++) begin
                rr_q[b]    <= '0;
                rd_id_q[b] <= '0;
            end
            rd_v_q   <= '0;
            dma_rd_q <= 1'b0;
            wait_q   <= '0;
        end else begin
            for (int b = 0; b < NumBanks; b++) begin
                if (!dma_sel && win_v[b]) rr_q[b] <= CoreIdW'((int'(win_id[b]) + 1) % NumCores);
                rd_v_q[b]  <= !dma_sel && win_v[b] && !core_q_write_i[win_id[b]];
                rd_id_q[b] <= win_id[b];
            end
            dma_rd_q <= dma_sel && !dma_q_write_i;
            wait_q   <= (dma_sel || !dma_q_valid_i) ? '0 :
                        (wait_q == WaitW'(MaxDmaStall) ? wait_q : wait_q + 1'b1);
        end
    end

endmodule

// File: tb/tb_snax_local_mem_arbiter.sv
// tb_snax_local_mem_arbiter: directed bench for the local memory arbiter with a behavioural bank array.
module tb_snax_local_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic [3:0]   core_q_valid, core_q_ready, core_q_write, core_p_valid;
    logic [63:0]  core_q_addr;
    logic [127:0] core_q_data, core_p_data;
    logic [15:0]  core_q_strb;
    logic         dma_q_valid, dma_q_ready, dma_q_write, dma_p_valid, dma_access;
    logic [15:0]  dma_q_addr;
    logic [511:0] dma_q_data, dma_p_data, pat;
    logic [63:0]  dma_q_strb;
    logic [15:0]  bank_req, bank_we;
    logic [159:0] bank_addr;
    logic [511:0] bank_wdata, bank_rdata;
    logic [63:0]  bank_be;
    logic [31:0]  mem [16][1024];
    logic [3:0]   rr_exp [4];
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    snax_local_mem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .core_q_valid_i(core_q_valid), .core_q_ready_o(core_q_ready), .core_q_addr_i(core_q_addr),
        .core_q_write_i(core_q_write), .core_q_data_i(core_q_data), .core_q_strb_i(core_q_strb),
        .core_p_valid_o(core_p_valid), .core_p_data_o(core_p_data),
        .dma_q_valid_i(dma_q_valid), .dma_q_ready_o(dma_q_ready), .dma_q_addr_i(dma_q_addr),
        .dma_q_write_i(dma_q_write), .dma_q_data_i(dma_q_data), .dma_q_strb_i(dma_q_strb),
        .dma_p_valid_o(dma_p_valid), .dma_p_data_o(dma_p_data), .dma_access_o(dma_access),
        .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_addr_o(bank_addr),
        .bank_wdata_o(bank_wdata), .bank_be_o(bank_be), .bank_rdata_i(bank_rdata)
    );

    // Bank array: one-cycle read latency, byte-enabled writes, preloaded while in reset.
    always @(posedge clk) begin
        if (!rst_ni) begin
            mem[1][1]  <= 32'hDEADBEEF;
            mem[2][3]  <= 32'h12345678;
            mem[3][7]  <= 32'h9ABCDEF0;
            bank_rdata <= '0;
        end else begin
            for (int b = 0; b < 16; b++) begin
                if (bank_req[b]) begin
                    if (bank_we[b])
                        for (int k = 0; k < 4; k++)
                            if (bank_be[b*4+k]) mem[b][bank_addr[b*10 +: 10]][8*k +: 8] <= bank_wdata[b*32+8*k +: 8];
                    bank_rdata[b*32 +: 32] <= mem[b][bank_addr[b*10 +: 10]];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        core_q_valid = '0; core_q_addr = '0; core_q_write = '0; core_q_data = '0; core_q_strb = '0;
        dma_q_valid = 1'b0; dma_q_addr = '0; dma_q_write = 1'b0; dma_q_data = '0; dma_q_strb = '0;
    endtask

    task automatic set_core(input int c, input logic [15:0] a, input logic w, input logic [31:0] d);
        core_q_valid[c]        = 1'b1;
        core_q_addr[c*16 +: 16] = a;
        core_q_write[c]        = w;
        core_q_data[c*32 +: 32] = d;
        core_q_strb[c*4 +: 4]   = 4'hF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        idle();
        for (int i = 0; i < 16; i++) pat[i*32 +: 32] = 32'hC0DE0000 | i;
        rr_exp = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
        repeat (3) @(posedge clk);
        #1;
        check("rst_core_p_valid", core_p_valid, 0);
        check("rst_dma_p_valid", dma_p_valid, 0);
        check("rst_core_p_data", core_p_data, 0);
        check("rst_dma_p_data", dma_p_data, 0);
        check("rst_bank_req_idle", bank_req, 0);
        @(negedge clk) rst_ni = 1'b1;

        // Core 1 reads bank 1 word 1
        @(negedge clk);
        set_core(1, 16'h0044, 1'b0, 32'h0);
        #1;
        check("t1_ready", core_q_ready, 4'b0010);
        check("t1_bank_req", bank_req, 16'h0002);
        check("t1_bank_addr", bank_addr[10 +: 10], 10'd1);
        @(posedge clk); #1;
        check("t1_p_valid", core_p_valid, 4'b0010);
        check("t1_p_data", core_p_data[32 +: 32], 32'hDEADBEEF);
        @(negedge clk) idle();

        // Cores 0,2,3 contend for bank 5
        @(negedge clk);
        set_core(0, 16'h0014, 1'b1, 32'h0);
        set_core(2, 16'h0014, 1'b1, 32'h0);
        set_core(3, 16'h0014, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_grant%0d", i), core_q_ready, rr_exp[i]);
            check($sformatf("rr_bank_req%0d", i), bank_req, 16'h0020);
            @(negedge clk);
        end
        idle();

        // DMA write then read of wide word 1
        @(negedge clk);
        dma_q_valid = 1'b1; dma_q_write = 1'b1; dma_q_addr = 16'h0040; dma_q_data = pat; dma_q_strb = '1;
        #1;
        check("dma_w_ready", dma_q_ready, 1'b1);
        check("dma_w_access", dma_access, 1'b1);
        check("dma_w_bank_req", bank_req, 16'hFFFF);
        check("dma_w_bank_we", bank_we, 16'hFFFF);
        check("dma_w_bank_addr", bank_addr, {16{10'd1}});
        check("dma_w_core_ready", core_q_ready, 4'b0000);
        @(negedge clk);
        dma_q_write = 1'b0;
        #1;
        check("dma_r_bank_we", bank_we, 16'h0000);
        @(posedge clk); #1;
        check("dma_r_p_valid", dma_p_valid, 1'b1);
        check("dma_r_p_data", dma_p_data, pat);
        @(negedge clk) idle();

        // DMA stalled behind saturating cores
        @(negedge clk);
        for (int c = 0; c < 4; c++) set_core(c, 16'(c << 2), 1'b1, 32'h0);
        dma_q_valid = 1'b1; dma_q_addr = 16'h0040;
        for (int k = 1; k <= 10; k++) begin
            #1;
            check($sformatf("stall_dma_ready%0d", k), dma_q_ready, k == 9);
            check($sformatf("stall_core_ready%0d", k), core_q_ready, k == 9 ? 4'b0000 : 4'b1111);
            @(negedge clk);
        end
        idle();

        // Cores 0 and 1 read banks 2 and 3 together
        @(negedge clk);
        set_core(0, 16'h00C8, 1'b0, 32'h0);
        set_core(1, 16'h01CC, 1'b0, 32'h0);
        #1;
        check("dual_ready", core_q_ready, 4'b0011);
        @(posedge clk); #1;
        check("dual_p_valid", core_p_valid, 4'b0011);
        check("dual_p_data", core_p_data, {32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678});
        @(negedge clk) idle();

        // Reset right after a core read grant drops the response and clears rr
        @(negedge clk);
        set_core(2, 16'h0014, 1'b0, 32'h0);
        #1;
        check("rst_mid_ready", core_q_ready, 4'b0100);
        @(posedge clk); #1;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_p_valid", core_p_valid, 4'b0000);
        idle();
        @(negedge clk);
        @(negedge clk) rst_ni = 1'b1;
        #1;
        check("rst_release_p_valid", core_p_valid, 4'b0000);
        @(negedge clk);
        set_core(0, 16'h0014, 1'b0, 32'h0);
        set_core(3, 16'h0014, 1'b0, 32'h0);
        #1;
        check("rst_rr_cleared", core_q_ready, 4'b0001);
        @(posedge clk); #1;
        check("rst_after_p_valid", core_p_valid, 4'b0001);
        @(negedge clk) idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
